// File: rtl/uart_pkg.sv
// uart_pkg -- definitions shared by the UART transmitter files.
//   DEFAULT_CLKS_PER_BIT : 10 MHz clock / 19200 baud
//   DATA_BITS            : bits per character
//   uart_state_e         : transmitter FSM encoding; the PARITY member exists
//                          only when UART_TX_PARITY_EN is defined
//   cnt_width()          : width of the per-bit cycle counter (minimum 1)
package uart_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 521;
  localparam int DATA_BITS            = 8;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START      = 3'd1,
    DATA_BURST = 3'd2,
    STOP       = 3'd3,
    PARITY     = 3'd4
  } uart_state_e;
`else
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START      = 3'd1,
    DATA_BURST = 3'd2,
    STOP       = 3'd3
  } uart_state_e;
`endif

  function automatic int cnt_width(input int clks);
    return (clks > 1) ? $clog2(clks) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if -- byte handshake into the UART transmitter.
//   tx_data  : byte to transmit (master -> slave)
//   tx_valid : tx_data is valid (master -> slave)
//   tx_ready : transmitter FIFO can accept a byte (slave -> master)
// Handshake: a byte transfers on every rising clock edge where
// tx_valid && tx_ready; tx_valid while tx_ready is low is ignored, and
// tx_ready does not depend on tx_valid.
interface uart_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input  tx_ready);
  modport slave  (input  tx_data, input  tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo -- synchronous FIFO with combinational read of the head entry.
//   clk, rst : clock, synchronous active-high reset (empties the FIFO)
//   push     : write wdata (ignored when full)
//   pop      : drop the head entry (ignored when empty)
//   wdata    : write data
//   rdata    : current head entry, valid while !empty
//   full     : count == DEPTH
//   empty    : count == 0
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int            AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_FULL);
  assign empty   = (count_q == '0);
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    // Simultaneous push and pop leaves the occupancy unchanged.
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/uart_tx.sv
// uart_tx -- FIFO-buffered 8N1 UART transmitter (8E1 with UART_TX_PARITY_EN).
//   tx_clk    : single clock, rising edge
//   tx_rst    : synchronous active-high reset; aborts any frame, empties FIFO
//   tx_in     : uart_tx_if.slave byte handshake (tx_data/tx_valid/tx_ready)
//   tx_out    : registered serial line, idles high
//   tx_busy   : high in every FSM state except IDLE
//   tx_done   : one-cycle pulse on the last cycle of each stop bit
//   dbg_state : current FSM state
// Optional feature macro: UART_TX_PARITY_EN adds an even-parity bit between
// data bit 7 and the stop bit (11-bit frame instead of 10).
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        tx_clk,
  input  logic        tx_rst,
  uart_tx_if.slave    tx_in,
  output logic        tx_out,
  output logic        tx_busy,
  output logic        tx_done,
  output uart_state_e dbg_state
);

  localparam int            CW      = cnt_width(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  uart_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_out_q, tx_out_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
`ifdef UART_TX_PARITY_EN
  logic          par_q, par_d;
`endif

  logic       fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0] fifo_rdata;
  logic       bit_last;

  assign tx_in.tx_ready = !fifo_full;
  assign fifo_push      = tx_in.tx_valid && !fifo_full;
  assign bit_last       = (cnt_q == CNT_MAX);

  uart_tx_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (tx_clk),
    .rst   (tx_rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (tx_in.tx_data),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    fifo_pop  = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d     = par_q;
`endif
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_rdata;
`ifdef UART_TX_PARITY_EN
          par_d    = ^fifo_rdata;
`endif
          state_d  = START;
          cnt_d    = '0;
        end
      end
      START: begin
        if (bit_last) begin
          state_d   = DATA_BURST;
          cnt_d     = '0;
          bit_idx_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      DATA_BURST: begin
        if (bit_last) begin
          cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            // LSB first: the line always carries shift[0].
            shift_d   = {1'b0, shift_q[7:1]};
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_last) begin
          state_d = STOP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
`endif
      STOP: begin
        if (bit_last) begin
          cnt_d = '0;
          // Chain straight into the next frame so there is no idle gap.
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_rdata;
`ifdef UART_TX_PARITY_EN
            par_d    = ^fifo_rdata;
`endif
            state_d  = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they register in step with it.
  always_comb begin
    tx_out_d = 1'b1;
    case (state_d)
      START:      tx_out_d = 1'b0;
      DATA_BURST: tx_out_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:     tx_out_d = par_d;
`endif
      default:    tx_out_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == STOP) && (cnt_d == CNT_MAX);
  end

  always_ff @(posedge tx_clk) begin
    if (tx_rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_out_q  <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_out_q  <= tx_out_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef UART_TX_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

  assign tx_out    = tx_out_q;
  assign tx_busy   = busy_q;
  assign tx_done   = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx -- directed bench for uart_tx.
// dut_a: CLKS_PER_BIT=4, FIFO_DEPTH=4.  dut_b: CLKS_PER_BIT=2 (minimum).
// Frame length follows UART_TX_PARITY_EN (11 bits with it, 10 without).
module tb_uart_tx;
  import uart_pkg::*;

  localparam int C_A   = 4;
  localparam int C_B   = 2;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_a, rst_b;
  always #5 clk = ~clk;

  uart_tx_if if_a ();
  uart_tx_if if_b ();

  logic        out_a, busy_a, done_a, out_b, busy_b, done_b;
  uart_state_e st_a, st_b;

  uart_tx #(.CLKS_PER_BIT(C_A), .FIFO_DEPTH(DEPTH)) dut_a (
    .tx_clk(clk), .tx_rst(rst_a), .tx_in(if_a),
    .tx_out(out_a), .tx_busy(busy_a), .tx_done(done_a), .dbg_state(st_a)
  );

  uart_tx #(.CLKS_PER_BIT(C_B), .FIFO_DEPTH(DEPTH)) dut_b (
    .tx_clk(clk), .tx_rst(rst_b), .tx_in(if_b),
    .tx_out(out_b), .tx_busy(busy_b), .tx_done(done_b), .dbg_state(st_b)
  );

  // ---------------- scoreboard state ----------------
  logic [7:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int frame_no = 0;
  int done_cnt_a = 0;
  int done_cnt_b = 0;
  int d0;

  always @(negedge clk) begin
    if (done_a === 1'b1) done_cnt_a++;
    if (done_b === 1'b1) done_cnt_b++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic push(input bit sel, input logic [7:0] d);
    if (sel) begin
      if_b.tx_data = d; if_b.tx_valid = 1'b1;
    end else begin
      if_a.tx_data = d; if_a.tx_valid = 1'b1;
    end
    tick();
    if_a.tx_valid = 1'b0;
    if_b.tx_valid = 1'b0;
  endtask

  // Checks one frame cycle by cycle, starting at cycle index 'skip' of the
  // frame (index 0 is the first start-bit cycle); ends one cycle after it.
  task automatic check_frame(input bit sel, input int skip);
    logic [7:0] d;
    logic       lvl, o, b, dn;
    int         c, pos;
    c = sel ? C_B : C_A;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $error("FAIL exp_q_underflow observed=0 expected=1");
      return;
    end
    d = exp_q.pop_front();
    frame_no++;
    for (int i = skip; i < FB * c; i++) begin
      pos = i / c;
      if (pos == 0)                   lvl = 1'b0;
      else if (pos <= 8)              lvl = d[pos-1];
      else if (FB == 11 && pos == 9)  lvl = ^d;
      else                            lvl = 1'b1;
      o  = sel ? out_b  : out_a;
      b  = sel ? busy_b : busy_a;
      dn = sel ? done_b : done_a;
      chk($sformatf("f%0d_out_c%0d", frame_no, i), 32'(o), 32'(lvl));
      chk($sformatf("f%0d_busy_c%0d", frame_no, i), 32'(b), 32'd1);
      chk($sformatf("f%0d_done_c%0d", frame_no, i), 32'(dn),
          (i == FB * c - 1) ? 32'd1 : 32'd0);
      tick();
    end
  endtask

  task automatic idle_check(input string tag);
    chk({tag, "_out"},   32'(out_a), 32'd1);
    chk({tag, "_busy"},  32'(busy_a), 32'd0);
    chk({tag, "_state"}, 32'(st_a), 32'(IDLE));
    chk({tag, "_ready"}, 32'(if_a.tx_ready), 32'd1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    if_a.tx_data = 8'h00; if_a.tx_valid = 1'b0;
    if_b.tx_data = 8'h00; if_b.tx_valid = 1'b0;
    rst_a = 1'b1; rst_b = 1'b1;
    tick(); tick();
    rst_a = 1'b0; rst_b = 1'b0;

    // Reset state
    idle_check("rst_a");
    chk("rst_a_done", 32'(done_a), 32'd0);
    chk("rst_b_out",  32'(out_b), 32'd1);
    chk("rst_b_busy", 32'(busy_b), 32'd0);
    chk("rst_b_ready", 32'(if_b.tx_ready), 32'd1);

    // Single byte 0xA5: line still high at N+1, start bit from N+2
    d0 = done_cnt_a;
    exp_q.push_back(8'hA5);
    push(1'b0, 8'hA5);
    chk("a5_n1_out", 32'(out_a), 32'd1);
    chk("a5_n1_state", 32'(st_a), 32'(IDLE));
    tick();
    check_frame(1'b0, 0);
    idle_check("a5_after");
    chk("a5_done_count", 32'(done_cnt_a - d0), 32'd1);

    // Back-to-back 0x00, 0xFF: no idle gap between frames
    d0 = done_cnt_a;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    push(1'b0, 8'h00);
    push(1'b0, 8'hFF);
    check_frame(1'b0, 0);
    check_frame(1'b0, 0);
    idle_check("b2b_after");
    chk("b2b_done_count", 32'(done_cnt_a - d0), 32'd2);

    // Six pushes into depth 4: five accepted, sixth refused
    d0 = done_cnt_a;
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("fill_ready_%0d", k), 32'(if_a.tx_ready), (k < 5) ? 32'd1 : 32'd0);
      if (k < 5) exp_q.push_back(8'h11 * (k + 1));
      push(1'b0, 8'(8'h11 * (k + 1)));
    end
    // Six pushes end four cycles into the first start bit.
    check_frame(1'b0, 4);
    for (int k = 0; k < 4; k++) check_frame(1'b0, 0);
    idle_check("fill_after");
    chk("fill_done_count", 32'(done_cnt_a - d0), 32'd5);
    chk("fill_exp_empty", 32'(exp_q.size()), 32'd0);

    // Reset during data bit 3 of 0x37 with two bytes queued
    d0 = done_cnt_a;
    push(1'b0, 8'h37);
    push(1'b0, 8'h5A);
    push(1'b0, 8'hC3);
    for (int k = 0; k < 16; k++) tick();
    chk("rst_mid_state", 32'(st_a), 32'(DATA_BURST));
    chk("rst_mid_bit3", 32'(out_a), 32'd0);
    rst_a = 1'b1;
    if_a.tx_data = 8'h55; if_a.tx_valid = 1'b1;
    tick();
    rst_a = 1'b0;
    if_a.tx_valid = 1'b0;
    idle_check("rst_mid_after");
    chk("rst_mid_done", 32'(done_a), 32'd0);
    for (int k = 0; k < 60; k++) begin
      tick();
      chk($sformatf("rst_quiet_out_%0d", k), 32'(out_a), 32'd1);
      chk($sformatf("rst_quiet_busy_%0d", k), 32'(busy_a), 32'd0);
    end
    chk("rst_mid_done_count", 32'(done_cnt_a - d0), 32'd0);

    // 0x07 then 0x03 (parity 1 then 0 when parity is enabled)
    d0 = done_cnt_a;
    exp_q.push_back(8'h07);
    exp_q.push_back(8'h03);
    push(1'b0, 8'h07);
    push(1'b0, 8'h03);
    check_frame(1'b0, 0);
    check_frame(1'b0, 0);
    idle_check("par_after");
    chk("par_done_count", 32'(done_cnt_a - d0), 32'd2);

    // Minimum CLKS_PER_BIT=2, byte 0x80
    d0 = done_cnt_b;
    exp_q.push_back(8'h80);
    push(1'b1, 8'h80);
    chk("b80_n1_out", 32'(out_b), 32'd1);
    tick();
    check_frame(1'b1, 0);
    chk("b80_after_out", 32'(out_b), 32'd1);
    chk("b80_after_busy", 32'(busy_b), 32'd0);
    chk("b80_done_count", 32'(done_cnt_b - d0), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
